// File: rtl/key_debounce_if.sv
// Key bus between the raw push-button pins and the debounced level/event outputs.
// The slave modport is the debouncer's view; the master modport is the board/bench side.
interface key_debounce_if #(
   parameter int KEY_W = 3
);
   logic [KEY_W-1:0] key_in;
   logic [KEY_W-1:0] key_out;
   logic [KEY_W-1:0] key_press;
   logic [KEY_W-1:0] key_release;

   modport master (
      output key_in,
      input  key_out,
      input  key_press,
      input  key_release
   );

   modport slave (
      input  key_in,
      output key_out,
      output key_press,
      output key_release
   );
endinterface

// File: rtl/key_debounce.sv
// Per-bit synchroniser and debouncer for active-low keys with one-cycle press/release pulses.
// Optional auto-repeat of key_press while a key is held: define KEY_REPEAT_EN.
module key_debounce #(
   parameter int KEY_W         = 3,
   parameter int DEB_CYCLES    = 1000000,
   parameter int REPEAT_DELAY  = 25000000,
   parameter int REPEAT_PERIOD = 5000000
) (
   input  logic           clk,
   input  logic           rst_n,
   key_debounce_if.slave  kif
);
   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [KEY_W-1:0] key_meta_p0;
   logic [KEY_W-1:0] key_sync;
   logic [KEY_W-1:0] key_q;
   logic [KEY_W-1:0] press_q;
   logic [KEY_W-1:0] release_q;
   logic [KEY_W-1:0] commit;
   logic [KEY_W-1:0] rep_fire;
   logic [CNT_W-1:0] cnt [KEY_W];

   // A bit commits when the synchronised level has disagreed for DEB_CYCLES edges in a row.
   always_comb begin
      commit = '0;
      for (int i = 0; i < KEY_W; i++) begin
         commit[i] = (key_sync[i] != key_q[i]) && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta_p0 <= '1;
         key_sync    <= '1;
         key_q       <= '1;
         press_q     <= '0;
         release_q   <= '0;
         for (int i = 0; i < KEY_W; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         key_meta_p0 <= kif.key_in;
         key_sync    <= key_meta_p0;
         press_q     <= (commit & ~key_sync) | rep_fire;
         release_q   <= commit & key_sync;
         for (int i = 0; i < KEY_W; i++) begin
            if (key_sync[i] == key_q[i]) begin
               cnt[i] <= '0;
            end else if (commit[i]) begin
               key_q[i] <= key_sync[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] DELAY_MAX  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_MAX = HOLD_W'(REPEAT_PERIOD - 1);

   logic [HOLD_W-1:0] hold [KEY_W];
   logic [KEY_W-1:0]  rep_phase;

   // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; a release commit wins over a repeat.
   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < KEY_W; i++) begin
         rep_fire[i] = !key_q[i] && !commit[i] &&
                       (hold[i] == (rep_phase[i] ? PERIOD_MAX : DELAY_MAX));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_phase <= '0;
         for (int i = 0; i < KEY_W; i++) begin
            hold[i] <= '0;
         end
      end else begin
         for (int i = 0; i < KEY_W; i++) begin
            if (key_q[i] || commit[i]) begin
               hold[i]      <= '0;
               rep_phase[i] <= 1'b0;
            end else if (rep_fire[i]) begin
               hold[i]      <= '0;
               rep_phase[i] <= 1'b1;
            end else begin
               hold[i] <= hold[i] + 1'b1;
            end
         end
      end
   end
`else
   assign rep_fire = '0;
`endif

   assign kif.key_out     = key_q;
   assign kif.key_press   = press_q;
   assign kif.key_release = release_q;
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_CYCLES=16 (REPEAT_DELAY=40, REPEAT_PERIOD=10).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_key_debounce;
   logic clk;
   logic rst_n;
   int   checks;
   int   passed;

   key_debounce_if #(.KEY_W(3)) kif ();

   key_debounce #(
      .KEY_W(3),
      .DEB_CYCLES(16),
      .REPEAT_DELAY(40),
      .REPEAT_PERIOD(10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .kif  (kif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int bad;
      rst_n = 1'b0;
      kif.key_in = 3'b111;
      #22;
      checks++;
      if (kif.key_out !== 3'b111) $display("FAIL reset_key_out: got %b want 111", kif.key_out);
      else passed++;
      checks++;
      if ({kif.key_press, kif.key_release} !== 6'b0)
         $display("FAIL reset_pulses: got press=%b release=%b want 000/000", kif.key_press, kif.key_release);
      else passed++;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (kif.key_out !== 3'b111 || kif.key_press !== 3'b0 || kif.key_release !== 3'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles want 0", bad);
      else passed++;
   endtask

   task automatic test_clean_press();
      int bad;
      kif.key_in = 3'b110;
      bad = 0;
      for (int c = 1; c <= 17; c++) begin
         step();
         if (kif.key_out !== 3'b111 || kif.key_press !== 3'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL press_early: got %0d early changes want 0", bad);
      else passed++;
      step();
      checks++;
      if (kif.key_out !== 3'b110) $display("FAIL press_key_out: got %b want 110", kif.key_out);
      else passed++;
      checks++;
      if (kif.key_press !== 3'b001) $display("FAIL press_pulse: got %b want 001", kif.key_press);
      else passed++;
      checks++;
      if (kif.key_release !== 3'b000) $display("FAIL press_no_release: got %b want 000", kif.key_release);
      else passed++;
      step();
      checks++;
      if (kif.key_press !== 3'b000 || kif.key_out !== 3'b110)
         $display("FAIL press_one_cycle: got press=%b out=%b want 000/110", kif.key_press, kif.key_out);
      else passed++;
   endtask

   task automatic test_clean_release();
      kif.key_in = 3'b111;
      for (int c = 1; c <= 18; c++) step();
      checks++;
      if (kif.key_out !== 3'b111 || kif.key_release !== 3'b001 || kif.key_press !== 3'b000)
         $display("FAIL release_bit0: got out=%b rel=%b press=%b want 111/001/000",
                  kif.key_out, kif.key_release, kif.key_press);
      else passed++;
      step();
      checks++;
      if (kif.key_release !== 3'b000) $display("FAIL release_one_cycle: got %b want 000", kif.key_release);
      else passed++;
   endtask

   task automatic test_bounce();
      int bad;
      int presses;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         if (c % 5 == 0) kif.key_in[1] = ~kif.key_in[1];
         step();
         if (kif.key_out !== 3'b111 || kif.key_press !== 3'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL bounce_rejected: got %0d bad cycles want 0", bad);
      else passed++;
      kif.key_in = 3'b101;
      bad = 0;
      for (int c = 1; c <= 17; c++) begin
         step();
         if (kif.key_out !== 3'b111) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL bounce_settle_early: got %0d early cycles want 0", bad);
      else passed++;
      step();
      checks++;
      if (kif.key_out !== 3'b101 || kif.key_press !== 3'b010)
         $display("FAIL bounce_commit: got out=%b press=%b want 101/010", kif.key_out, kif.key_press);
      else passed++;
      presses = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (kif.key_press !== 3'b000) presses++;
      end
      checks++;
      if (presses !== 0) $display("FAIL bounce_single_press: got %0d extra presses want 0", presses);
      else passed++;
   endtask

   task automatic test_simultaneous();
      kif.key_in = 3'b011;
      for (int c = 1; c <= 17; c++) step();
      checks++;
      if (kif.key_out !== 3'b101) $display("FAIL simul_early: got %b want 101", kif.key_out);
      else passed++;
      step();
      checks++;
      if (kif.key_out !== 3'b011) $display("FAIL simul_key_out: got %b want 011", kif.key_out);
      else passed++;
      checks++;
      if (kif.key_press !== 3'b100) $display("FAIL simul_press: got %b want 100", kif.key_press);
      else passed++;
      checks++;
      if (kif.key_release !== 3'b010) $display("FAIL simul_release: got %b want 010", kif.key_release);
      else passed++;
      kif.key_in = 3'b111;
      for (int c = 1; c <= 18; c++) step();
      checks++;
      if (kif.key_out !== 3'b111 || kif.key_release !== 3'b100)
         $display("FAIL simul_release_all: got out=%b rel=%b want 111/100", kif.key_out, kif.key_release);
      else passed++;
   endtask

   task automatic test_glitch();
      int bad;
      bad = 0;
      kif.key_in = 3'b011;
      for (int c = 0; c < 15; c++) begin
         step();
         if (kif.key_out !== 3'b111 || kif.key_press !== 3'b0 || kif.key_release !== 3'b0) bad++;
      end
      kif.key_in = 3'b111;
      for (int c = 0; c < 40; c++) begin
         step();
         if (kif.key_out !== 3'b111 || kif.key_press !== 3'b0 || kif.key_release !== 3'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL glitch_15: got %0d disturbed cycles want 0", bad);
      else passed++;
   endtask

   task automatic test_async_reset();
      int bad;
      kif.key_in = 3'b110;
      for (int c = 1; c <= 18; c++) step();
      checks++;
      if (kif.key_out !== 3'b110) $display("FAIL areset_setup: got %b want 110", kif.key_out);
      else passed++;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (kif.key_out !== 3'b111) $display("FAIL areset_async: got %b want 111", kif.key_out);
      else passed++;
      #2;
      rst_n = 1'b1;
      bad = 0;
      for (int c = 1; c <= 17; c++) begin
         step();
         if (kif.key_out !== 3'b111 || kif.key_press !== 3'b0) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL areset_redebounce_early: got %0d early cycles want 0", bad);
      else passed++;
      step();
      checks++;
      if (kif.key_out !== 3'b110 || kif.key_press !== 3'b001)
         $display("FAIL areset_fresh_press: got out=%b press=%b want 110/001", kif.key_out, kif.key_press);
      else passed++;
      kif.key_in = 3'b111;
      for (int c = 1; c <= 18; c++) step();
      checks++;
      if (kif.key_out !== 3'b111) $display("FAIL areset_cleanup: got %b want 111", kif.key_out);
      else passed++;
   endtask

`ifdef KEY_REPEAT_EN
   task automatic test_repeat();
      int bad;
      int presses;
      logic exp_press;
      kif.key_in = 3'b110;
      for (int c = 1; c <= 18; c++) step();
      checks++;
      if (kif.key_press !== 3'b001) $display("FAIL repeat_accept: got %b want 001", kif.key_press);
      else passed++;
      bad = 0;
      presses = 0;
      for (int t = 1; t <= 150; t++) begin
         if (t == 133) kif.key_in = 3'b111;
         step();
         exp_press = (t >= 40) && (t <= 140) && (t % 10 == 0);
         if (kif.key_press[0] === 1'b1) presses++;
         if (kif.key_press !== {2'b00, exp_press}) bad++;
         if (kif.key_release !== ((t == 150) ? 3'b001 : 3'b000)) bad++;
      end
      checks++;
      if (bad !== 0) $display("FAIL repeat_pattern: got %0d wrong cycles want 0", bad);
      else passed++;
      checks++;
      if (presses !== 11) $display("FAIL repeat_count: got %0d repeats want 11", presses);
      else passed++;
      presses = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (kif.key_press !== 3'b000) presses++;
      end
      checks++;
      if (presses !== 0) $display("FAIL repeat_after_release: got %0d presses want 0", presses);
      else passed++;
   endtask
`endif

   initial begin
      checks = 0;
      passed = 0;
      rst_n = 1'b0;
      kif.key_in = 3'b111;
      test_reset();
      test_clean_press();
      test_clean_release();
      test_bounce();
      test_simultaneous();
      test_glitch();
      test_async_reset();
`ifdef KEY_REPEAT_EN
      test_repeat();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation ran past 200000 time units");
      $fatal(1, "timeout");
   end
endmodule
